// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 16;

    localparam logic CPU = 1'b0;
    localparam logic DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin pick: on a tie the port not served last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic last,
    output logic valid,
    output logic pick
);

    always_comb begin
        valid = cpu_req | dbg_req;
        pick  = CPU;
        if (cpu_req && dbg_req) begin
            pick = (last == CPU) ? DBG : CPU;
        end else if (dbg_req) begin
            pick = DBG;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a CPU port and a debug/loader port onto one single-ported memory,
// one access at a time: accept, issue, optional read-latency wait, response.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,

    input  logic          dbg_hold,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // WAIT covers RD_LAT-1 cycles; the counter value on its final cycle.
    localparam bit         HAS_WAIT  = (RD_LAT > 1);
    localparam logic [1:0] WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    state_t        state_q, state_d;
    logic          port_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          last_q;
    logic [1:0]    cnt_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dbg_rdata_q;

    logic cpu_eff;
    logic pick_valid;
    logic pick_port;
    logic is_issue;
    logic is_resp;

    assign cpu_eff = cpu_req & ~dbg_hold;

    rr_pick2 u_pick (
        .cpu_req (cpu_eff),
        .dbg_req (dbg_req),
        .last    (last_q),
        .valid   (pick_valid),
        .pick    (pick_port)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (pick_valid) state_d = ISSUE;
            ISSUE: begin
                if (we_q)          state_d = IDLE;
                else if (HAS_WAIT) state_d = WAIT;
                else               state_d = RESP;
            end
            WAIT:  if (cnt_q == WAIT_LAST) state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            port_q      <= CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            last_q      <= DBG;
            cnt_q       <= 2'd0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_valid) begin
                port_q  <= pick_port;
                we_q    <= (pick_port == DBG) ? dbg_we    : cpu_we;
                addr_q  <= (pick_port == DBG) ? dbg_addr  : cpu_addr;
                wdata_q <= (pick_port == DBG) ? dbg_wdata : cpu_wdata;
            end
            if (state_q == ISSUE) begin
                last_q <= port_q;
            end
            cnt_q <= (state_q == WAIT) ? cnt_q + 2'd1 : 2'd0;
            // Capture the delivered word so rdata holds once rvalid drops.
            if (state_q == RESP) begin
                if (port_q == CPU) cpu_rdata_q <= mem_rdata;
                else               dbg_rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        is_issue   = (state_q == ISSUE);
        is_resp    = (state_q == RESP);
        mem_en     = is_issue;
        mem_we     = is_issue & we_q;
        mem_addr   = is_issue ? addr_q  : '0;
        mem_wdata  = is_issue ? wdata_q : '0;
        cpu_gnt    = is_issue & (port_q == CPU);
        dbg_gnt    = is_issue & (port_q == DBG);
        cpu_rvalid = is_resp  & (port_q == CPU);
        dbg_rvalid = is_resp  & (port_q == DBG);
        cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;
    end

endmodule
